// File: rtl/blit_line_ctrl.sv
// Command sequencer for the Bresenham line engine: sequences start/setup timing,
// clips engine pixels, maps them to framebuffer byte addresses and applies back-pressure.
module blit_line_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int COLOR_W = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [15:0]        cmd_x1,
  input  logic [15:0]        cmd_y1,
  input  logic [15:0]        cmd_x2,
  input  logic [15:0]        cmd_y2,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [15:0]        clip_x0,
  input  logic [15:0]        clip_y0,
  input  logic [15:0]        clip_x1,
  input  logic [15:0]        clip_y1,
  input  logic [ADDR_W-1:0]  fb_base,
  input  logic [15:0]        fb_pitch,
  input  logic               abort,
  output logic [15:0]        line_x1,
  output logic [15:0]        line_y1,
  output logic [15:0]        line_x2,
  output logic [15:0]        line_y2,
  output logic               line_start,
  output logic               line_stall,
  input  logic [15:0]        line_x,
  input  logic [15:0]        line_y,
  input  logic               line_done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic [31:0]        pix_count
);

  typedef enum logic [1:0] {IDLE, SETUP, PRIME, DRAW} state_t;

  state_t state_reg, state_next;

  logic [15:0]        x1_reg, y1_reg, x2_reg, y2_reg;
  logic signed [15:0] cx0_reg, cy0_reg, cx1_reg, cy1_reg;
  logic [COLOR_W-1:0] color_reg;
  logic [ADDR_W-1:0]  base_reg;
  logic [15:0]        pitch_reg;
  logic [31:0]        pix_count_reg;

  logic in_clip, drawing, retire, last_pix, accept;

  assign drawing = (state_reg == DRAW);
  assign in_clip = ($signed(line_x) >= cx0_reg) && ($signed(line_x) <= cx1_reg) &&
                   ($signed(line_y) >= cy0_reg) && ($signed(line_y) <= cy1_reg);

  assign pix_valid  = drawing && in_clip;
  assign line_stall = drawing && in_clip && !pix_ready;
  assign retire     = drawing && !line_stall;
  assign last_pix   = retire && line_done;

  // Abort outranks everything, so no command may be taken in its cycle.
  assign cmd_ready  = !abort && ((state_reg == IDLE) || last_pix);
  assign accept     = cmd_valid && cmd_ready;

  assign line_start = (state_reg == PRIME) || drawing;
  assign busy       = (state_reg != IDLE);

  assign line_x1   = x1_reg;
  assign line_y1   = y1_reg;
  assign line_x2   = x2_reg;
  assign line_y2   = y2_reg;
  assign pix_color = color_reg;
  assign pix_count = pix_count_reg;

  // Coordinates are treated as unsigned here; clipped pixels are never non-negative-violating.
  assign pix_addr = base_reg + ADDR_W'(line_y) * ADDR_W'(pitch_reg) + ADDR_W'(line_x);

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = SETUP;
        SETUP:   state_next = PRIME;
        PRIME:   state_next = DRAW;
        DRAW:    if (last_pix) state_next = accept ? SETUP : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      x1_reg        <= '0;
      y1_reg        <= '0;
      x2_reg        <= '0;
      y2_reg        <= '0;
      cx0_reg       <= '0;
      cy0_reg       <= '0;
      cx1_reg       <= '0;
      cy1_reg       <= '0;
      color_reg     <= '0;
      base_reg      <= '0;
      pitch_reg     <= '0;
      pix_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x1_reg    <= cmd_x1;
        y1_reg    <= cmd_y1;
        x2_reg    <= cmd_x2;
        y2_reg    <= cmd_y2;
        cx0_reg   <= clip_x0;
        cy0_reg   <= clip_y0;
        cx1_reg   <= clip_x1;
        cy1_reg   <= clip_y1;
        color_reg <= cmd_color;
        base_reg  <= fb_base;
        pitch_reg <= fb_pitch;
      end
      if (pix_valid && pix_ready) pix_count_reg <= pix_count_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_blit_line_ctrl.sv
// Directed bench for blit_line_ctrl with a simple stepping line-engine model.
module tb_blit_line_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_x1 = '0, cmd_y1 = '0, cmd_x2 = '0, cmd_y2 = '0;
  logic [7:0]  cmd_color = 8'h5A;
  logic [15:0] clip_x0 = 16'd0, clip_y0 = 16'd0, clip_x1 = 16'd639, clip_y1 = 16'd479;
  logic [31:0] fb_base = 32'h1000;
  logic [15:0] fb_pitch = 16'd640;
  logic        abort = 1'b0;
  logic [15:0] line_x1, line_y1, line_x2, line_y2;
  logic        line_start, line_stall;
  logic [15:0] line_x, line_y;
  logic        line_done;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [31:0] pix_addr;
  logic [7:0]  pix_color;
  logic        busy;
  logic [31:0] pix_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  blit_line_ctrl #(.ADDR_W(32), .COLOR_W(8)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
    .cmd_color(cmd_color),
    .clip_x0(clip_x0), .clip_y0(clip_y0), .clip_x1(clip_x1), .clip_y1(clip_y1),
    .fb_base(fb_base), .fb_pitch(fb_pitch), .abort(abort),
    .line_x1(line_x1), .line_y1(line_y1), .line_x2(line_x2), .line_y2(line_y2),
    .line_start(line_start), .line_stall(line_stall),
    .line_x(line_x), .line_y(line_y), .line_done(line_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_color(pix_color),
    .busy(busy), .pix_count(pix_count)
  );

  // Engine model: loads x1,y1 on the first start cycle, then steps toward x2,y2 unless stalled.
  logic signed [15:0] ex, ey;
  logic               start_q;
  assign line_x    = ex;
  assign line_y    = ey;
  assign line_done = (ex == $signed(line_x2)) && (ey == $signed(line_y2));

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b0;
      ex      <= '0;
      ey      <= '0;
    end else begin
      start_q <= line_start;
      if (line_start && !start_q) begin
        ex <= $signed(line_x1);
        ey <= $signed(line_y1);
      end else if (line_start && !line_stall && !line_done) begin
        if (ex < $signed(line_x2)) ex <= ex + 16'sd1;
        else if (ex > $signed(line_x2)) ex <= ex - 16'sd1;
        if (ey < $signed(line_y2)) ey <= ey + 16'sd1;
        else if (ey > $signed(line_y2)) ey <= ey - 16'sd1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  // Presents a command and returns 1ns after its accept edge (cycle 1 of the line).
  task automatic issue(input int ax1, input int ay1, input int ax2, input int ay2, input bit keep);
    int n;
    cmd_x1 = 16'(ax1); cmd_y1 = 16'(ay1);
    cmd_x2 = 16'(ax2); cmd_y2 = 16'(ay2);
    cmd_valid = 1'b1;
    n = 0;
    #1;
    while (!cmd_ready && n < 20) begin
      nxt;
      n++;
    end
    if (n >= 20) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clock);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  logic rdy2   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int   addr2  [7] = '{102, 202, 202, 202, 202, 302, 402};
  logic stall2 [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_line_start", 64'(line_start), 64'd0);
    check("rst_pix_count", 64'(pix_count), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    nxt;

    // Horizontal line (0,0)-(3,0)
    issue(0, 0, 3, 0, 1'b0);
    check("h_setup_start", 64'(line_start), 64'd0);
    check("h_setup_busy", 64'(busy), 64'd1);
    nxt;
    check("h_prime_start", 64'(line_start), 64'd1);
    check("h_prime_valid", 64'(pix_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      nxt;
      check($sformatf("h_valid%0d", i), 64'(pix_valid), 64'd1);
      check($sformatf("h_addr%0d", i), 64'(pix_addr), 64'(32'h1000 + i));
      check($sformatf("h_cmd_ready%0d", i), 64'(cmd_ready), 64'(i == 3));
    end
    check("h_color", 64'(pix_color), 64'h5A);
    nxt;
    check("h_idle", 64'(busy), 64'd0);
    check("h_count", 64'(pix_count), 64'd4);

    // Back-pressure (2,1)-(2,4)
    fb_base = 32'd0; fb_pitch = 16'd100;
    issue(2, 1, 2, 4, 1'b0);
    nxt;
    for (int c = 0; c < 7; c++) begin
      nxt;
      pix_ready = rdy2[c];
      #1;
      check($sformatf("bp_valid%0d", c), 64'(pix_valid), 64'd1);
      check($sformatf("bp_addr%0d", c), 64'(pix_addr), 64'(addr2[c]));
      check($sformatf("bp_stall%0d", c), 64'(line_stall), 64'(stall2[c]));
    end
    nxt;
    pix_ready = 1'b1;
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_count", 64'(pix_count), 64'd8);

    // Clipping (-2,5)-(2,5); ready held low on clipped pixels
    fb_pitch = 16'd10;
    issue(-2, 5, 2, 5, 1'b0);
    nxt;
    for (int c = 0; c < 5; c++) begin
      nxt;
      pix_ready = (c >= 2);
      #1;
      check($sformatf("clip_valid%0d", c), 64'(pix_valid), 64'(c >= 2));
      check($sformatf("clip_stall%0d", c), 64'(line_stall), 64'd0);
      if (c >= 2) check($sformatf("clip_addr%0d", c), 64'(pix_addr), 64'(50 + c - 2));
    end
    nxt;
    check("clip_idle", 64'(busy), 64'd0);
    check("clip_count", 64'(pix_count), 64'd11);

    // Back-to-back: (0,0)-(1,1) then (3,0)-(4,0)
    fb_base = 32'h1000; fb_pitch = 16'd640;
    issue(0, 0, 1, 1, 1'b1);
    cmd_x1 = 16'd3; cmd_y1 = 16'd0; cmd_x2 = 16'd4; cmd_y2 = 16'd0;
    #1;
    check("b2b_setup_ready", 64'(cmd_ready), 64'd0);
    nxt;
    nxt;
    check("b2b_addr0", 64'(pix_addr), 64'h1000);
    check("b2b_ready0", 64'(cmd_ready), 64'd0);
    nxt;
    check("b2b_addr1", 64'(pix_addr), 64'h1281);
    check("b2b_ready1", 64'(cmd_ready), 64'd1);
    nxt;
    cmd_valid = 1'b0;
    check("b2b_setup_start", 64'(line_start), 64'd0);
    check("b2b_setup_busy", 64'(busy), 64'd1);
    nxt;
    check("b2b_prime_start", 64'(line_start), 64'd1);
    nxt;
    check("b2b_addr2", 64'(pix_addr), 64'h1003);
    nxt;
    check("b2b_addr3", 64'(pix_addr), 64'h1004);
    nxt;
    check("b2b_idle", 64'(busy), 64'd0);
    check("b2b_count", 64'(pix_count), 64'd15);

    // Degenerate (7,7)-(7,7)
    fb_base = 32'd0; fb_pitch = 16'd16;
    issue(7, 7, 7, 7, 1'b0);
    check("deg_busy1", 64'(busy), 64'd1);
    nxt;
    check("deg_busy2", 64'(busy), 64'd1);
    nxt;
    check("deg_busy3", 64'(busy), 64'd1);
    check("deg_addr", 64'(pix_addr), 64'd119);
    check("deg_valid", 64'(pix_valid), 64'd1);
    nxt;
    check("deg_idle", 64'(busy), 64'd0);
    check("deg_count", 64'(pix_count), 64'd16);

    // Abort mid-line on (0,0)-(9,0)
    fb_pitch = 16'd640;
    issue(0, 0, 9, 0, 1'b0);
    nxt;
    nxt;
    nxt;
    nxt;
    abort = 1'b1;
    #1;
    check("ab_addr", 64'(pix_addr), 64'd2);
    check("ab_cmd_ready", 64'(cmd_ready), 64'd0);
    nxt;
    abort = 1'b0;
    #1;
    check("ab_idle", 64'(busy), 64'd0);
    check("ab_start", 64'(line_start), 64'd0);
    check("ab_valid", 64'(pix_valid), 64'd0);
    check("ab_count", 64'(pix_count), 64'd19);
    nxt;
    check("ab_valid_later", 64'(pix_valid), 64'd0);

    // Reset mid-line
    issue(0, 0, 9, 0, 1'b0);
    nxt;
    nxt;
    nxt;
    pix_ready = 1'b0;
    #1;
    check("rs_stall_before", 64'(line_stall), 64'd1);
    resetn = 1'b0;
    #1;
    check("rs_stall", 64'(line_stall), 64'd0);
    check("rs_valid", 64'(pix_valid), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rs_count", 64'(pix_count), 64'd0);
    check("rs_line_x2", 64'(line_x2), 64'd0);
    check("rs_start", 64'(line_start), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    pix_ready = 1'b1;
    nxt;
    fb_pitch = 16'd16;
    issue(7, 7, 7, 7, 1'b0);
    nxt;
    nxt;
    check("rs_restart_addr", 64'(pix_addr), 64'd119);
    check("rs_restart_valid", 64'(pix_valid), 64'd1);
    nxt;
    check("rs_restart_count", 64'(pix_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
